voice_mix_engine: RTL and testbench

- Parametrised, time-multiplexed voice mixer that sits after the per-voice ADSR stage.
- Accepts one voice sample per cycle, applies a per-voice gain from an internal gain RAM and accumulates a full frame of NUM_VOICES samples.
- At frame end it emits one shifted, saturated mixed sample.
- Also self-initialises its gain RAM and detects and recovers from out-of-sequence voice indices.

---
 rtl/voice_mix_engine.sv | 234 +++++++++++++++++++++++
 tb/tb_voice_mix_engine.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_mix_engine.sv
// Time-multiplexed voice mixer: per-voice gain from an internal RAM, frame accumulation,
// shift and saturation to one mixed sample per frame. Self-initialises gains to unity.
module voice_mix_engine #(
   parameter int unsigned NUM_VOICES  = 256,
   parameter int unsigned VOICE_IDX_W = 8,
   parameter int unsigned SAMPLE_W    = 16,
   parameter int unsigned GAIN_W      = 8,
   parameter int unsigned ACC_W       = 26,
   parameter int unsigned OUT_W       = 24
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_valid,
   input  logic [VOICE_IDX_W-1:0] i_voice_index,
   input  logic [SAMPLE_W-1:0]    i_sample,
   input  logic [2:0]             i_shift,
   input  logic                   i_cfg_we,
   input  logic [VOICE_IDX_W-1:0] i_cfg_voice,
   input  logic [GAIN_W-1:0]      i_cfg_gain,
   output logic                   o_busy,
   output logic                   o_valid,
   output logic [OUT_W-1:0]       o_sample,
   output logic                   o_clip,
   output logic                   o_seq_err
);

   localparam int unsigned PROD_W = SAMPLE_W + GAIN_W + 1;
   localparam int unsigned SCL_W  = SAMPLE_W + 2;
   localparam int unsigned SUM_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

   localparam logic [VOICE_IDX_W-1:0] LAST_IDX = VOICE_IDX_W'(NUM_VOICES - 1);
   localparam logic [VOICE_IDX_W-1:0] ONE_IDX  = VOICE_IDX_W'(1);
   localparam logic [GAIN_W-1:0]      UNITY    = {1'b1, {(GAIN_W-1){1'b0}}};

   localparam logic signed [SUM_W-1:0] OUT_MAX = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] OUT_MIN = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_INIT,
      ST_SYNC,
      ST_ACCUM
   } state_t;

   state_t                   state, state_nxt;
   logic [VOICE_IDX_W-1:0]   init_cnt, init_cnt_nxt;
   logic [VOICE_IDX_W-1:0]   expected, expected_nxt;
   logic                     accept, first_in, last_in, clr_in, seq_err_in;

   logic [GAIN_W-1:0]        gain_ram [NUM_VOICES];
   logic                     ram_we;
   logic [VOICE_IDX_W-1:0]   ram_addr;
   logic [GAIN_W-1:0]        ram_wdata;

   // stage 1
   logic                     v1, first1, last1, clr1;
   logic [SAMPLE_W-1:0]      sample1;
   logic [GAIN_W-1:0]        gain1;
   logic [2:0]               shift1;
   // stage 2 (product, then scaled)
   logic                     v2, first2, last2, clr2;
   logic [2:0]               shift2;
   logic signed [PROD_W-1:0] prod2;
   logic                     v3, first3, last3, clr3;
   logic [2:0]               shift3;
   logic signed [SCL_W-1:0]  scaled3;
   // stage 3
   logic signed [ACC_W-1:0]  acc, acc_base, sum, shifted;
   logic signed [SUM_W-1:0]  wide;
   logic [OUT_W-1:0]         sat;
   logic                     clip;

   assign o_busy = (state == ST_INIT);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state    <= ST_INIT;
         init_cnt <= '0;
         expected <= '0;
      end else begin
         state    <= state_nxt;
         init_cnt <= init_cnt_nxt;
         expected <= expected_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      init_cnt_nxt = init_cnt;
      expected_nxt = expected;
      accept       = 1'b0;
      first_in     = 1'b0;
      last_in      = 1'b0;
      clr_in       = 1'b0;
      seq_err_in   = 1'b0;
      unique case (state)
         ST_INIT: begin
            init_cnt_nxt = init_cnt + ONE_IDX;
            if (init_cnt == LAST_IDX) state_nxt = ST_SYNC;
         end
         ST_SYNC: begin
            if (i_valid && (i_voice_index == '0)) begin
               accept   = 1'b1;
               first_in = 1'b1;
               if (LAST_IDX == '0) begin
                  last_in = 1'b1;
               end else begin
                  state_nxt    = ST_ACCUM;
                  expected_nxt = ONE_IDX;
               end
            end
         end
         ST_ACCUM: begin
            if (i_valid) begin
               if (i_voice_index == expected) begin
                  accept = 1'b1;
                  if (expected == LAST_IDX) begin
                     last_in   = 1'b1;
                     state_nxt = ST_SYNC;
                  end else begin
                     expected_nxt = expected + ONE_IDX;
                  end
               end else begin
                  seq_err_in = 1'b1;
                  if (i_voice_index == '0) begin
                     accept       = 1'b1;
                     first_in     = 1'b1;
                     expected_nxt = ONE_IDX;
                  end else begin
                     clr_in    = 1'b1;
                     state_nxt = ST_SYNC;
                  end
               end
            end
         end
         default: state_nxt = ST_INIT;
      endcase
   end

   always_comb begin
      ram_we    = i_cfg_we;
      ram_addr  = i_cfg_voice;
      ram_wdata = i_cfg_gain;
      if (state == ST_INIT) begin
         ram_we    = 1'b1;
         ram_addr  = init_cnt;
         ram_wdata = UNITY;
      end
   end

   // Read-before-write: a same-cycle cfg write to the read address yields the old gain.
   always_ff @(posedge i_clk) begin
      if (ram_we) gain_ram[ram_addr] <= ram_wdata;
      gain1 <= gain_ram[i_voice_index];
   end

   // Product is registered ahead of the scaling register so o_valid lands three cycles
   // after the last voice while the accumulator clears on the output edge.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         v1 <= 1'b0; first1 <= 1'b0; last1 <= 1'b0; clr1 <= 1'b0;
         v2 <= 1'b0; first2 <= 1'b0; last2 <= 1'b0; clr2 <= 1'b0;
         v3 <= 1'b0; first3 <= 1'b0; last3 <= 1'b0; clr3 <= 1'b0;
         sample1   <= '0;
         shift1    <= '0;
         shift2    <= '0;
         shift3    <= '0;
         prod2     <= '0;
         scaled3   <= '0;
         o_seq_err <= 1'b0;
      end else begin
         v1        <= accept;
         first1    <= first_in;
         last1     <= last_in;
         clr1      <= clr_in;
         sample1   <= i_sample;
         shift1    <= i_shift;
         o_seq_err <= seq_err_in;

         v2     <= v1;
         first2 <= first1;
         last2  <= last1;
         clr2   <= clr1;
         shift2 <= shift1;
         prod2  <= $signed(sample1) * $signed({1'b0, gain1});

         v3      <= v2;
         first3  <= first2;
         last3   <= last2;
         clr3    <= clr2;
         shift3  <= shift2;
         scaled3 <= SCL_W'(prod2 >>> (GAIN_W - 1));
      end
   end

   always_comb begin
      acc_base = first3 ? '0 : acc;
      sum      = acc_base + ACC_W'(scaled3);
      shifted  = sum >>> shift3;
      wide     = SUM_W'(shifted);
      sat      = wide[OUT_W-1:0];
      clip     = 1'b0;
      if (wide > OUT_MAX) begin
         sat  = OUT_MAX[OUT_W-1:0];
         clip = 1'b1;
      end else if (wide < OUT_MIN) begin
         sat  = OUT_MIN[OUT_W-1:0];
         clip = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         acc      <= '0;
         o_valid  <= 1'b0;
         o_sample <= '0;
         o_clip   <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         if (clr3) begin
            acc <= '0;
         end else if (v3) begin
            if (last3) begin
               acc      <= '0;
               o_valid  <= 1'b1;
               o_sample <= sat;
               o_clip   <= clip;
            end else begin
               acc <= sum;
            end
         end
      end
   end

endmodule

// File: tb/tb_voice_mix_engine.sv
// Bench for voice_mix_engine: directed test-plan steps followed by random traffic,
// every cycle checked against a frame-level reference model.
module tb_voice_mix_engine;

   localparam int NV = 4;

   logic        clk = 1'b0;
   logic        rst, valid, cfg_we;
   logic [1:0]  vidx, cfg_voice;
   logic [15:0] sample;
   logic [2:0]  shift;
   logic [7:0]  cfg_gain;
   logic        busy, ovalid, clip, seq_err;
   logic [15:0] osample;

   always #5 clk = ~clk;

   voice_mix_engine #(
      .NUM_VOICES (NV),
      .VOICE_IDX_W(2),
      .SAMPLE_W   (16),
      .GAIN_W     (8),
      .ACC_W      (20),
      .OUT_W      (16)
   ) dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_valid      (valid),
      .i_voice_index(vidx),
      .i_sample     (sample),
      .i_shift      (shift),
      .i_cfg_we     (cfg_we),
      .i_cfg_voice  (cfg_voice),
      .i_cfg_gain   (cfg_gain),
      .o_busy       (busy),
      .o_valid      (ovalid),
      .o_sample     (osample),
      .o_clip       (clip),
      .o_seq_err    (seq_err)
   );

   typedef struct {
      int due;
      int val;
      bit clp;
   } ev_t;

   ev_t evq[$];
   int  gains[NV];
   int  busy_cnt, exp_idx, frame_sum, cyc, exp_sample;
   bit  in_frame, exp_seq;
   int  checks = 0, errors = 0;
   int  out_count, last_out, busy_seen, seq_count, end_cyc;
   bit  last_clip;
   int  vcyc[$];

   function automatic int floor_div(int a, int d);
      int q;
      q = a / d;
      if ((a % d != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   task automatic chk(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
      checks++;
      assert (act === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic model_edge(input bit v, input int idx, input int smp, input int sh,
                             input bit we, input int cv, input int cg, input bit r);
      int sc, total, val;
      bit clp;
      cyc++;
      exp_seq = 1'b0;
      if (r) begin
         busy_cnt = NV;
         in_frame = 1'b0;
         foreach (gains[i]) gains[i] = 128;
         evq.delete();
         exp_sample = 0;
         return;
      end
      if (busy_cnt > 0) begin
         busy_cnt--;
         return;
      end
      if (v) begin
         sc = floor_div(smp * gains[idx], 128);
         if (in_frame && idx != exp_idx) begin
            exp_seq  = 1'b1;
            in_frame = 1'b0;
         end
         if (!in_frame && idx == 0) begin
            in_frame  = 1'b1;
            frame_sum = 0;
            exp_idx   = 0;
         end
         if (in_frame && idx == exp_idx) begin
            frame_sum += sc;
            exp_idx++;
            if (exp_idx == NV) begin
               total = floor_div(frame_sum, 1 << sh);
               val   = total;
               clp   = 1'b0;
               if (total > 32767) begin val = 32767; clp = 1'b1; end
               else if (total < -32768) begin val = -32768; clp = 1'b1; end
               evq.push_back('{cyc + 3, val, clp});
               in_frame = 1'b0;
            end
         end
      end
      if (we) gains[cv] = cg;
   endtask

   task automatic check_outputs();
      ev_t ev;
      bit  exp_v;
      chk("o_busy", busy, busy_cnt > 0);
      chk("o_seq_err", seq_err, exp_seq);
      exp_v = (evq.size() > 0) && (evq[0].due == cyc);
      chk("o_valid", ovalid, exp_v);
      if (exp_v) begin
         ev = evq.pop_front();
         exp_sample = ev.val;
         chk("o_clip", clip, ev.clp);
      end
      chk("o_sample", $signed(osample), exp_sample);
      if (busy === 1'b1) busy_seen++;
      if (seq_err === 1'b1) seq_count++;
      if (ovalid === 1'b1) begin
         out_count++;
         last_out  = $signed(osample);
         last_clip = clip;
         vcyc.push_back(cyc);
      end
   endtask

   task automatic step(input bit v, input int idx, input int smp, input int sh = 0,
                       input bit we = 1'b0, input int cv = 0, input int cg = 0, input bit r = 1'b0);
      valid     = v;
      vidx      = idx[1:0];
      sample    = smp[15:0];
      shift     = sh[2:0];
      cfg_we    = we;
      cfg_voice = cv[1:0];
      cfg_gain  = cg[7:0];
      rst       = r;
      @(posedge clk);
      model_edge(v, idx, smp, sh, we, cv, cg, r);
      #1;
      check_outputs();
   endtask

   task automatic send(input int idx, input int smp, input int sh = 0);
      step(1'b1, idx, smp, sh);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 0, 0);
   endtask

   task automatic frame4(input int a, input int b, input int c, input int d, input int sh = 0);
      send(0, a, sh);
      send(1, b, sh);
      send(2, c, sh);
      send(3, d, sh);
   endtask

   task automatic set_gain(input int v, input int g);
      step(1'b0, 0, 0, 0, 1'b1, v, g);
   endtask

   int rv, ridx, rsmp, rsh, rwe, rcv, rcg, rr, nidx;

   initial begin
      rst = 1'b1; valid = 1'b0; vidx = '0; sample = '0; shift = '0;
      cfg_we = 1'b0; cfg_voice = '0; cfg_gain = '0;
      cyc = 0; busy_cnt = NV; exp_sample = 0; in_frame = 1'b0;
      out_count = 0; seq_count = 0; busy_seen = 0;
      foreach (gains[i]) gains[i] = 128;

      // reset, then busy window with ignored samples and cfg writes
      step(0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      busy_seen = 0;
      step(0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(1'b1, (i + 1) % 4, 5000, 0, 1'b1, i, 3);
      idle(6);
      chk("busy_cycles", busy_seen, 4);
      chk("init_no_output", out_count, 0);

      // unity mix, back-to-back
      vcyc.delete();
      frame4(1000, 2000, 3000, 4000);
      end_cyc = cyc;
      frame4(1000, 2000, 3000, 4000);
      idle(5);
      chk("unity_count", out_count, 2);
      chk("unity_val", last_out, 10000);
      chk("unity_clip", last_clip, 0);
      chk("unity_latency", vcyc[0] - end_cyc, 3);
      chk("b2b_spacing", vcyc[1] - vcyc[0], 4);

      // gain and shift
      set_gain(0, 64);
      frame4(1000, 2000, 3000, 4000);
      idle(4);
      chk("gain64", last_out, 9500);
      set_gain(0, 128);
      frame4(1000, 2000, 3000, 4000, 2);
      idle(4);
      chk("shift2", last_out, 2500);
      send(0, 1000);
      step(1'b1, 1, 2000, 0, 1'b1, 1, 0);
      send(2, 3000);
      send(3, 4000);
      idle(4);
      chk("same_cycle_old_gain", last_out, 10000);
      frame4(1000, 2000, 3000, 4000);
      idle(4);
      chk("new_gain_applied", last_out, 8000);
      set_gain(1, 128);

      // saturation
      for (int v = 0; v < NV; v++) set_gain(v, 255);
      frame4(32767, 32767, 32767, 32767);
      idle(4);
      chk("sat_pos", last_out, 32767);
      chk("sat_pos_clip", last_clip, 1);
      for (int v = 0; v < NV; v++) set_gain(v, 128);
      frame4(-32768, -32768, -32768, -32768);
      idle(4);
      chk("sat_neg", last_out, -32768);
      chk("sat_neg_clip", last_clip, 1);

      // sequence errors
      out_count = 0; seq_count = 0;
      send(0, 1000); send(1, 1000); send(3, 1000);
      idle(4);
      chk("seq_err_pulses", seq_count, 1);
      chk("seq_no_output", out_count, 0);
      frame4(1000, 1000, 1000, 1000);
      idle(4);
      chk("seq_recover", last_out, 4000);
      out_count = 0; seq_count = 0;
      send(0, 100); send(1, 200);
      frame4(1000, 2000, 3000, 4000);
      idle(4);
      chk("restart_err_pulses", seq_count, 1);
      chk("restart_count", out_count, 1);
      chk("restart_val", last_out, 10000);

      // mid-frame reset restores unity gains
      set_gain(2, 10);
      out_count = 0;
      send(0, 1000); send(1, 2000);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      idle(NV + 2);
      chk("reset_no_output", out_count, 0);
      chk("reset_sample_zero", $signed(osample), 0);
      frame4(1000, 2000, 3000, 4000);
      idle(4);
      chk("unity_after_reset", last_out, 10000);

      // random traffic against the model
      nidx = 0;
      for (int i = 0; i < 600; i++) begin
         rv   = ($urandom_range(0, 9) != 0);
         ridx = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : nidx;
         rsmp = int'($urandom_range(0, 65535)) - 32768;
         rsh  = $urandom_range(0, 7);
         rwe  = ($urandom_range(0, 7) == 0);
         rcv  = $urandom_range(0, 3);
         rcg  = $urandom_range(0, 255);
         rr   = ($urandom_range(0, 249) == 0);
         step(rv[0], ridx, rsmp, rsh, rwe[0], rcv, rcg, rr[0]);
         if (rr != 0) nidx = 0;
         else if (rv != 0) nidx = (ridx + 1) % NV;
      end
      idle(8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
